// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg
// Shared definitions for the write-channel responder: field widths,
// bit positions inside the aw/w/b message buses, response codes and
// the responder FSM state encoding.
package axi_wr_pkg;

    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam int AW_MSG_W = ID_W + LEN_W + ADDR_W;       // 44
    localparam int W_MSG_W  = STRB_W + 1 + DATA_W;         // 73
    localparam int B_MSG_W  = ID_W + 2;                    // 6

    // aw message: {id, len, addr}
    localparam int AW_ADDR_LSB = 0;
    localparam int AW_ADDR_MSB = 31;
    localparam int AW_LEN_LSB  = 32;
    localparam int AW_LEN_MSB  = 39;
    localparam int AW_ID_LSB   = 40;
    localparam int AW_ID_MSB   = 43;

    // w message: {strb, last, data}
    localparam int W_DATA_LSB = 0;
    localparam int W_DATA_MSB = 63;
    localparam int W_LAST_BIT = 64;
    localparam int W_STRB_LSB = 65;
    localparam int W_STRB_MSB = 72;

    // b message: {id, resp}
    localparam int B_RESP_LSB = 0;
    localparam int B_RESP_MSB = 1;
    localparam int B_ID_LSB   = 2;
    localparam int B_ID_MSB   = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_wr_strb_merge.sv
// axi_wr_strb_merge
// Combinational byte-strobe merge: each byte of the result comes from
// new_data when its strobe bit is set, otherwise from old_data.
// Ports:
//   old_data  in   current register contents
//   new_data  in   write beat data
//   strb      in   per-byte write enables
//   merged    out  merged 64-bit value
module axi_wr_strb_merge
    import axi_wr_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [STRB_W-1:0] strb,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_data[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_wr_resp_regs.sv
// axi_wr_resp_regs
// Write-channel responder (slave end) in front of a bank of 64-bit
// registers. Accepts one aw command, then len+1 write beats, then
// returns a single b response carrying the command id and an OKAY or
// SLVERR code. Beats update registers under byte strobes.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   w_slave0_aw_*     command channel  {id, len, addr}
//   w_slave0_w_*      data channel     {strb, last, data}
//   w_slave0_b_*      response channel {id, resp}
//   regs_q            flattened register contents, reg i at [64*i +: 64]
//   wr_pulse          one-cycle strobe per register written
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting for a command, aw_rdy = 1
// ST_DATA | accepting beats, w_rdy = 1, ends on beat count == len
// ST_RESP | holding b_val/b_msg until the master takes the response
module axi_wr_resp_regs
    import axi_wr_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          STRIDE_LOG2 = 3,
    parameter logic [63:0] RESET_VAL   = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW_MSG_W-1:0]    w_slave0_aw_msg,
    input  logic                   w_slave0_aw_val,
    output logic                   w_slave0_aw_rdy,
    input  logic [W_MSG_W-1:0]     w_slave0_w_msg,
    input  logic                   w_slave0_w_val,
    output logic                   w_slave0_w_rdy,
    output logic [B_MSG_W-1:0]     w_slave0_b_msg,
    output logic                   w_slave0_b_val,
    input  logic                   w_slave0_b_rdy,
    output logic [NUM_REGS*64-1:0] regs_q,
    output logic [NUM_REGS-1:0]    wr_pulse
);

    localparam int                IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] STRIDE_BYTES = ADDR_W'(1) << STRIDE_LOG2;
    localparam logic [ADDR_W-1:0] ALIGN_MASK   = STRIDE_BYTES - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] NUM_REGS_A   = ADDR_W'(NUM_REGS);

    // message field decode
    logic [ID_W-1:0]   aw_id;
    logic [LEN_W-1:0]  aw_len;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic [STRB_W-1:0] w_strb;

    assign aw_id   = w_slave0_aw_msg[AW_ID_MSB:AW_ID_LSB];
    assign aw_len  = w_slave0_aw_msg[AW_LEN_MSB:AW_LEN_LSB];
    assign aw_addr = w_slave0_aw_msg[AW_ADDR_MSB:AW_ADDR_LSB];
    assign w_data  = w_slave0_w_msg[W_DATA_MSB:W_DATA_LSB];
    assign w_last  = w_slave0_w_msg[W_LAST_BIT];
    assign w_strb  = w_slave0_w_msg[W_STRB_MSB:W_STRB_LSB];

    // FSM state and registered outputs
    wr_state_t          state_q, state_d;
    logic               aw_rdy_q, aw_rdy_d;
    logic               w_rdy_q,  w_rdy_d;
    logic               b_val_q,  b_val_d;
    logic [B_MSG_W-1:0] b_msg_q,  b_msg_d;

    // burst context
    logic [ID_W-1:0]   id_q,   id_d;
    logic [LEN_W-1:0]  len_q,  len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q,  cnt_d;
    logic              err_q,  err_d;

    assign w_slave0_aw_rdy = aw_rdy_q;
    assign w_slave0_w_rdy  = w_rdy_q;
    assign w_slave0_b_val  = b_val_q;
    assign w_slave0_b_msg  = b_msg_q;

    // Ready/valid flops are only ever set in their own state, so the
    // handshake terms need no extra state qualification.
    logic aw_fire, w_fire, b_fire;
    assign aw_fire = w_slave0_aw_val & aw_rdy_q;
    assign w_fire  = w_slave0_w_val  & w_rdy_q;
    assign b_fire  = b_val_q & w_slave0_b_rdy;

    // Address decode. The extra top bit of the subtraction flags an
    // address below BASE_ADDR rather than letting it wrap into range.
    logic [ADDR_W:0]   offset_ext;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] idx_full;
    logic [IDX_W-1:0]  idx;
    logic              addr_ok;

    assign offset_ext = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign offset     = offset_ext[ADDR_W-1:0];
    assign idx_full   = offset >> STRIDE_LOG2;
    assign idx        = idx_full[IDX_W-1:0];
    assign addr_ok    = !offset_ext[ADDR_W]
                        && ((offset & ALIGN_MASK) == '0)
                        && (idx_full < NUM_REGS_A);

    logic final_beat, beat_err;
    assign final_beat = (cnt_q == len_q);
    // last must coincide exactly with the counted final beat
    assign beat_err   = !addr_ok || (w_last != final_beat);

    // register bank
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] merged;

    axi_wr_strb_merge u_merge (
        .old_data (regs[idx]),
        .new_data (w_data),
        .strb     (w_strb),
        .merged   (merged)
    );

    always_comb begin
        state_d  = state_q;
        aw_rdy_d = aw_rdy_q;
        w_rdy_d  = w_rdy_q;
        b_val_d  = b_val_q;
        b_msg_d  = b_msg_q;
        id_d     = id_q;
        len_d    = len_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (aw_fire) begin
                    id_d     = aw_id;
                    len_d    = aw_len;
                    addr_d   = aw_addr;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ST_DATA;
                    aw_rdy_d = 1'b0;
                    w_rdy_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    addr_d = addr_q + STRIDE_BYTES;
                    cnt_d  = cnt_q + LEN_W'(1);
                    err_d  = err_q | beat_err;
                    if (final_beat) begin
                        state_d = ST_RESP;
                        w_rdy_d = 1'b0;
                        b_val_d = 1'b1;
                        b_msg_d = {id_q, resp_code(err_d)};
                    end
                end
            end
            ST_RESP: begin
                if (b_fire) begin
                    state_d  = ST_IDLE;
                    b_val_d  = 1'b0;
                    aw_rdy_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                aw_rdy_d = 1'b1;
                w_rdy_d  = 1'b0;
                b_val_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            aw_rdy_q <= 1'b1;
            w_rdy_q  <= 1'b0;
            b_val_q  <= 1'b0;
            b_msg_q  <= '0;
            id_q     <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_rdy_q <= aw_rdy_d;
            w_rdy_q  <= w_rdy_d;
            b_val_q  <= b_val_d;
            b_msg_q  <= b_msg_d;
            id_q     <= id_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (w_fire && addr_ok) begin
                regs[idx] <= merged;
                if (|w_strb) begin
                    wr_pulse[idx] <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_q[64*gi +: 64] = regs[gi];
    end

endmodule
